// File: rtl/booth_seq_mult_if.sv
// Start/done handshake and operand/result bus for the sequential Booth multiplier.
`timescale 1ns/1ps
interface booth_seq_mult_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 start;
  logic                 sgn;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, sgn, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, sgn, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier, one Booth step per clock, signed or unsigned per operation.
`timescale 1ns/1ps
module booth_seq_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  booth_seq_mult_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int unsigned CW  = $clog2(WIDTH + 2);

  logic [1:0]           state, state_nxt;
  logic [WIDTH+1:0]     a, sum, m_ext;
  logic [WIDTH:0]       m, q;
  logic                 q_1;
  logic [CW-1:0]        cnt;
  logic                 busy_r, done_r;
  logic [2*WIDTH-1:0]   prod_r;
  logic                 accept, last;
  logic [2*WIDTH-1:0]   prod_nxt;

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = prod_r;

  always_comb begin
    accept = bus.start && ((state == IDLE) || (state == DONE));
    last   = (state == RUN) && (cnt == CW'(1));
    m_ext  = {m[WIDTH], m};
    unique case ({q[0], q_1})
      2'b01:   sum = a + m_ext;
      2'b10:   sum = a - m_ext;
      default: sum = a;
    endcase
    // low 2*WIDTH bits of the shifted {A,Q} after this step
    prod_nxt = {sum[WIDTH-1:0], q[WIDTH:1]};

    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a      <= '0;
      m      <= '0;
      q      <= '0;
      q_1    <= 1'b0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      prod_r <= '0;
    end else begin
      state  <= state_nxt;
      busy_r <= (state_nxt == RUN);
      done_r <= (state_nxt == DONE);
      if (accept) begin
        m   <= {bus.sgn & bus.multiplicand[WIDTH-1], bus.multiplicand};
        q   <= {bus.sgn & bus.multiplier[WIDTH-1], bus.multiplier};
        a   <= '0;
        q_1 <= 1'b0;
        cnt <= CW'(WIDTH + 1);
      end else if (state == RUN) begin
        a   <= {sum[WIDTH+1], sum[WIDTH+1:1]};
        q   <= {sum[0], q[WIDTH:1]};
        q_1 <= q[0];
        cnt <= cnt - 1'b1;
        if (last) prod_r <= prod_nxt;
      end
    end
  end
endmodule

// File: doc/booth_seq_mult.md
# booth_seq_mult

Parametrised sequential radix-2 Booth multiplier: the multi-cycle successor of the team's combinational 8x8 signed Booth multiplier. It multiplies two WIDTH-bit operands, signed or unsigned, selected per operation. It retires one Booth step per clock under a start/done handshake. It is for datapaths where multiplier area matters more than latency. The product register holds its value until the next accepted start.

## Interface
- WIDTH, 8, operand width in bits; legal range 4..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when the block is not busy.
- sgn  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- multiplicand  input  WIDTH  operand M; sampled with start.
- multiplier  input  WIDTH  operand Q; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; product is valid from this cycle on.
- product  output  2*WIDTH  result; signed when sgn=1, unsigned when sgn=0.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Accept condition: start=1 while in IDLE or DONE. On accept:
  - latch M and Q, each extended to WIDTH+1 bits (sign-extended if sgn=1, zero-extended if sgn=0);
  - clear accumulator A (WIDTH+2 bits) and q_1;
  - load iteration counter with WIDTH+1;
  - go to RUN.
- RUN, one step per cycle, based on {Q[0],q_1}:
  - 01: A = A + M (M sign-extended to WIDTH+2 bits);
  - 10: A = A - M;
  - 00 and 11: A unchanged.
  - Then arithmetic right shift of {A,Q,q_1} by one.
  - Decrement the counter.
- Final RUN step (counter reaches 0): load product with the low 2*WIDTH bits of {A,Q}, go to DONE.
- DONE lasts exactly one cycle. Next state is RUN if start=1, otherwise IDLE.
- The width rules make every result exact: -2^(W-1)*-2^(W-1) and (2^W-1)^2 both fit in 2*WIDTH bits, with no overflow or wrap.
- start, sgn and operands are ignored while in RUN. Operand changes mid-operation do not affect the result.
- Reset, asserted at any time including mid-RUN, aborts immediately. All state clears and no done pulse is produced for the aborted operation.

## Timing
- Reset values: busy=0, done=0, product=0, state=IDLE, counter=0.
- Accept at rising edge k: busy=1 from edge k.
- WIDTH+1 Booth steps occur at edges k+1 .. k+WIDTH+1.
- At edge k+WIDTH+1: product updates, done=1, busy=0. Latency is WIDTH+1 cycles from accept to done.
- At edge k+WIDTH+2: done returns to 0. If start=1 during the DONE cycle, a new operation is accepted at that edge and busy rises again (back-to-back throughput: one result per WIDTH+2 cycles).
- busy and done are never high together.
- product changes only at the final RUN edge or at reset. It holds through IDLE and through the whole of the next operation.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, sgn=1, M=3, Q=4, start for one cycle -> done high exactly 9 cycles after accept, product=12. Repeat with M=-3 -> product=-12 (0xFFF4).
- WIDTH=8, sgn=1, corner pairs:
  - -128*-128 -> 16384 (0x4000);
  - -128*1 -> -128 (0xFF80);
  - 127*127 -> 16129;
  - 7*-8 -> -56.
- WIDTH=8, sgn=0, 255*255 -> 65025 (0xFE01), and 128*2 -> 256. The same bit patterns with sgn=1 give -1*-1=1 and -128*2=-256.
- During RUN, toggle start and change operands every cycle -> no re-accept, busy stays high, result matches the originally latched operands, and exactly one done pulse.
- Assert rst_n low at step 4 of an operation -> busy, done and product read 0 immediately. After release, a fresh 5*6 completes with product=30 and no stray done pulse.
- WIDTH=16 instance, back-to-back operations with start held high through DONE:
  - -32768*-32768 -> 0x40000000, then 65535*65535 unsigned -> 0xFFFE0001;
  - done pulses are 18 cycles apart.
